// File: rtl/eval_pipe_module.sv
// Three-stage evaluation pipe: result = mode ? ROM(a[AW-1:0]) + ~b + a : ~b + a; one global stall holds every stage.
// Output appears three edges after capture; in_ready tracks !out_valid | out_ready. Macro SATURATE_EN clamps both additions.
module eval_pipe_module #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_mode,
  output logic [15:0]   kernel_count
);

  function automatic logic [DW-1:0] rom_lookup(input logic [AW-1:0] addr);
    logic [DW-1:0] r;
    r = DW'(3);
    case (addr)
      AW'(0): r = DW'(57);
      AW'(1): r = DW'(61);
      AW'(2): r = DW'(22);
      AW'(3): r = DW'(98);
      AW'(4): r = DW'(121);
      AW'(5): r = DW'(17);
      AW'(6): r = DW'(13);
      default: r = DW'(3);
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] add_op(input logic [DW-1:0] x, input logic [DW-1:0] y);
`ifdef SATURATE_EN
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
`else
    return x + y;
`endif
  endfunction

  logic          adv;
  logic          s1_valid, s1_mode;
  logic [DW-1:0] s1_a, s1_nb, s1_rom;
  logic          s2_valid, s2_mode;
  logic [DW-1:0] s2_a, s2_sum;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Stage 1: operand capture; the ROM register is enabled only by valid kernel samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_a     <= '0;
      s1_nb    <= '0;
      s1_rom   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_a     <= in_a;
      s1_nb    <= ~in_b;
      if (in_valid && in_mode)
        s1_rom <= rom_lookup(in_a[AW-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_a     <= '0;
      s2_sum   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_a     <= s1_a;
      s2_sum   <= s1_mode ? add_op(s1_rom, s1_nb) : s1_nb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_mode   <= 1'b0;
      out_result <= '0;
    end else if (adv) begin
      out_valid  <= s2_valid;
      out_mode   <= s2_mode;
      out_result <= add_op(s2_sum, s2_a);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      kernel_count <= '0;
    else if (out_valid && out_ready && out_mode)
      kernel_count <= kernel_count + 16'd1;
  end

endmodule

// File: tb/tb_eval_pipe_module.sv
// Directed bench for eval_pipe_module: inputs change and outputs are sampled around the falling edge.
module tb_eval_pipe_module;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_mode;
  logic [15:0] kernel_count;

  int tests;
  int fails;

  logic [7:0] st_a [16];
  logic [7:0] st_b [16];
  logic       st_m [16];
  logic [7:0] rs_d [32];
  logic       rs_m [32];
  int         rs_cyc [32];
  int         acc_cyc [16];
  int         nres;
  int         stall_cycles;
  bit         ready_in_stall;

  eval_pipe_module #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_mode(out_mode),
    .kernel_count(kernel_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives n samples from st_*, holds out_ready low for stall_len cycles from stall_from,
  // records every output transfer, and runs 4 extra cycles to catch duplicates.
  task automatic run_stream(input int n, input int stall_from, input int stall_len);
    int sent;
    int cyc;
    int extra;
    sent = 0; cyc = 0; extra = 0;
    nres = 0; stall_cycles = 0; ready_in_stall = 0;
    while (cyc < 200 && extra < 4) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (sent < n) begin
        in_valid = 1'b1; in_a = st_a[sent]; in_b = st_b[sent]; in_mode = st_m[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        stall_cycles++;
        if (in_ready) ready_in_stall = 1;
      end
      if (out_valid && out_ready && nres < 32) begin
        rs_d[nres] = out_result; rs_m[nres] = out_mode; rs_cyc[nres] = cyc; nres++;
      end
      if (in_valid && in_ready) begin
        acc_cyc[sent] = cyc; sent++;
      end
      if (nres >= n) extra++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b1;
    #12;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_result !== 8'h00) begin fails++; $display("FAIL reset_out_result got %h want 00", out_result); end
    tests++; if (out_mode !== 1'b0) begin fails++; $display("FAIL reset_out_mode got %b want 0", out_mode); end
    tests++; if (kernel_count !== 16'd0) begin fails++; $display("FAIL reset_kernel_count got %0d want 0", kernel_count); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_kernel_basic();
    logic [7:0] exp_r;
`ifdef SATURATE_EN
    exp_r = 8'hFF;
`else
    exp_r = 8'h38;
`endif
    st_a[0] = 8'h00; st_b[0] = 8'h00; st_m[0] = 1'b1;
    run_stream(1, 1000, 0);
    tests++; if (nres !== 1) begin fails++; $display("FAIL kernel_basic_count got %0d want 1", nres); end
    tests++; if (rs_d[0] !== exp_r) begin fails++; $display("FAIL kernel_basic_result got %h want %h", rs_d[0], exp_r); end
    tests++; if (rs_m[0] !== 1'b1) begin fails++; $display("FAIL kernel_basic_mode got %b want 1", rs_m[0]); end
    tests++; if (rs_cyc[0] - acc_cyc[0] !== 3) begin fails++; $display("FAIL kernel_basic_latency got %0d want 3", rs_cyc[0] - acc_cyc[0]); end
    tests++; if (kernel_count !== 16'd1) begin fails++; $display("FAIL kernel_basic_kcount got %0d want 1", kernel_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp1;
`ifdef SATURATE_EN
    exp1 = 8'hFF;
`else
    exp1 = 8'h00;
`endif
    st_a[0] = 8'h05; st_b[0] = 8'hFA; st_m[0] = 1'b0;
    st_a[1] = 8'h10; st_b[1] = 8'h0F; st_m[1] = 1'b0;
    run_stream(2, 1000, 0);
    tests++; if (nres !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", nres); end
    tests++; if (rs_d[0] !== 8'h0A) begin fails++; $display("FAIL b2b_result0 got %h want 0a", rs_d[0]); end
    tests++; if (rs_d[1] !== exp1) begin fails++; $display("FAIL b2b_result1 got %h want %h", rs_d[1], exp1); end
    tests++; if (rs_cyc[1] - rs_cyc[0] !== 1) begin fails++; $display("FAIL b2b_spacing got %0d want 1", rs_cyc[1] - rs_cyc[0]); end
    tests++; if (rs_m[0] !== 1'b0 || rs_m[1] !== 1'b0) begin fails++; $display("FAIL b2b_mode got %b%b want 00", rs_m[0], rs_m[1]); end
    tests++; if (kernel_count !== 16'd1) begin fails++; $display("FAIL b2b_kcount got %0d want 1", kernel_count); end
  endtask

  task automatic test_kernel_overflow();
    logic [7:0] exp_r;
`ifdef SATURATE_EN
    exp_r = 8'hFF;
`else
    exp_r = 8'h7C;
`endif
    st_a[0] = 8'h04; st_b[0] = 8'h00; st_m[0] = 1'b1;
    run_stream(1, 1000, 0);
    tests++; if (nres !== 1) begin fails++; $display("FAIL overflow_count got %0d want 1", nres); end
    tests++; if (rs_d[0] !== exp_r) begin fails++; $display("FAIL overflow_result got %h want %h", rs_d[0], exp_r); end
    tests++; if (kernel_count !== 16'd2) begin fails++; $display("FAIL overflow_kcount got %0d want 2", kernel_count); end
  endtask

  task automatic test_alternating();
    logic [7:0] exp_r [8];
    exp_r[0] = 8'd57; exp_r[1] = 8'd1;  exp_r[2] = 8'd24; exp_r[3] = 8'd3;
    exp_r[4] = 8'd125; exp_r[5] = 8'd5; exp_r[6] = 8'd19; exp_r[7] = 8'd7;
    for (int i = 0; i < 8; i++) begin
      st_a[i] = 8'(i); st_b[i] = 8'hFF; st_m[i] = (i % 2 == 0);
    end
    run_stream(8, 1000, 0);
    tests++; if (nres !== 8) begin fails++; $display("FAIL alt_count got %0d want 8", nres); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rs_d[i] !== exp_r[i] || rs_m[i] !== (i % 2 == 0)) begin
        fails++; $display("FAIL alt_result[%0d] got %0d/%b want %0d/%b", i, rs_d[i], rs_m[i], exp_r[i], (i % 2 == 0));
      end
    end
    tests++; if (kernel_count !== 16'd6) begin fails++; $display("FAIL alt_kcount got %0d want 6", kernel_count); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_r [6];
    exp_r[0] = 8'h59; exp_r[1] = 8'h21; exp_r[2] = 8'h38;
    exp_r[3] = 8'h23; exp_r[4] = 8'h9D; exp_r[5] = 8'h25;
    for (int i = 0; i < 6; i++) begin
      st_a[i] = 8'h20 + 8'(i); st_b[i] = 8'hFF; st_m[i] = (i % 2 == 0);
    end
    run_stream(6, 5, 4);
    tests++; if (nres !== 6) begin fails++; $display("FAIL stall_count got %0d want 6", nres); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rs_d[i] !== exp_r[i]) begin fails++; $display("FAIL stall_result[%0d] got %h want %h", i, rs_d[i], exp_r[i]); end
    end
    tests++; if (stall_cycles !== 4) begin fails++; $display("FAIL stall_cycles got %0d want 4", stall_cycles); end
    tests++; if (ready_in_stall !== 1'b0) begin fails++; $display("FAIL stall_in_ready got %b want 0", ready_in_stall); end
    tests++; if (kernel_count !== 16'd9) begin fails++; $display("FAIL stall_kcount got %0d want 9", kernel_count); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_a = 8'(i); in_b = 8'h00; in_mode = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || kernel_count !== 16'd9) begin
      fails++; $display("FAIL midrst_before got %b/%0d want 1/9", out_valid, kernel_count);
    end
    #1 rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    tests++; if (kernel_count !== 16'd0) begin fails++; $display("FAIL midrst_kcount got %0d want 0", kernel_count); end
    @(negedge clk); rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    st_a[0] = 8'h03; st_b[0] = 8'hF0; st_m[0] = 1'b1;
    run_stream(1, 1000, 0);
    tests++; if (nres !== 1) begin fails++; $display("FAIL midrst_count got %0d want 1", nres); end
    tests++; if (rs_d[0] !== 8'h74) begin fails++; $display("FAIL midrst_result got %h want 74", rs_d[0]); end
    tests++; if (rs_cyc[0] - acc_cyc[0] !== 3) begin fails++; $display("FAIL midrst_latency got %0d want 3", rs_cyc[0] - acc_cyc[0]); end
    tests++; if (kernel_count !== 16'd1) begin fails++; $display("FAIL midrst_kcount_after got %0d want 1", kernel_count); end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_kernel_basic();
    test_back_to_back();
    test_kernel_overflow();
    test_alternating();
    test_stall();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
